// File: rtl/ir_prefetch_queue.sv
// Instruction register fed by a DEPTH-entry prefetch FIFO, with valid/ready on
// both the fetch and issue sides and two-word (opcode + immediate) support.
module ir_prefetch_queue #(
  parameter int DATA_W = 16,
  parameter int FIELD_W = 4,
  parameter int DEPTH = 4,
  parameter logic [FIELD_W-1:0] IMM_OPCODE = FIELD_W'(4'hF)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       issue_valid,
  input  logic                       issue_ready,
  output logic [FIELD_W-1:0]         opcode,
  output logic [FIELD_W-1:0]         addrA,
  output logic [FIELD_W-1:0]         addrB,
  output logic [FIELD_W-1:0]         addrC,
  output logic [DATA_W-1:0]          ir,
  output logic [DATA_W-1:0]          imm,
  output logic                       has_imm,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] S_EMPTY    = 2'd0;
  localparam logic [1:0] S_WAIT_IMM = 2'd1;
  localparam logic [1:0] S_READY    = 2'd2;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [1:0]        state;
  logic [DATA_W-1:0] head;
  logic              head_imm, push, pop, fifo_nonempty;

  assign head          = mem[rd_ptr];
  assign head_imm      = (head[DATA_W-1 -: FIELD_W] == IMM_OPCODE);
  assign fifo_nonempty = (count != '0);
  assign in_ready      = (count != CW'(DEPTH));
  assign push          = in_valid && in_ready && !flush;
  // The FSM is the only consumer; READY pops only when the current IR is taken.
  assign pop = !flush && fifo_nonempty &&
               ((state == S_EMPTY) || (state == S_WAIT_IMM) ||
                ((state == S_READY) && issue_ready));

  assign issue_valid = (state == S_READY);
  assign fifo_count  = count;
  assign opcode      = ir[DATA_W-1 -: FIELD_W];
  assign addrA       = ir[3*FIELD_W-1 -: FIELD_W];
  assign addrB       = ir[2*FIELD_W-1 -: FIELD_W];
  assign addrC       = ir[FIELD_W-1 -: FIELD_W];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_EMPTY;
      ir      <= '0;
      imm     <= '0;
      has_imm <= 1'b0;
    end else if (flush) begin
      // ir/imm deliberately retained; only the handshake state is dropped.
      state   <= S_EMPTY;
      has_imm <= 1'b0;
    end else begin
      case (state)
        S_EMPTY: begin
          if (pop) begin
            ir    <= head;
            state <= head_imm ? S_WAIT_IMM : S_READY;
          end
        end
        S_WAIT_IMM: begin
          if (pop) begin
            imm     <= head;
            has_imm <= 1'b1;
            state   <= S_READY;
          end
        end
        S_READY: begin
          if (issue_ready) begin
            has_imm <= 1'b0;
            if (pop) begin
              ir    <= head;
              state <= head_imm ? S_WAIT_IMM : S_READY;
            end else begin
              state <= S_EMPTY;
            end
          end
        end
        default: state <= S_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_ir_prefetch_queue.sv
// Directed and scoreboarded checks for ir_prefetch_queue at default parameters.
module tb_ir_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        issue_valid;
  logic        issue_ready = 1'b0;
  logic [3:0]  opcode, addrA, addrB, addrC;
  logic [15:0] ir, imm;
  logic        has_imm;
  logic [2:0]  fifo_count;

  int tests = 0;
  int fails = 0;

  ir_prefetch_queue dut (
    .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .opcode(opcode), .addrA(addrA), .addrB(addrB), .addrC(addrC), .ir(ir),
    .imm(imm), .has_imm(has_imm), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; issue_ready = 1'b0; flush = 1'b0;
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    in_valid = 1'b0; issue_ready = 1'b0; flush = 1'b0;
    rst = 1'b0;
    step();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready_during: got %b want 1", in_ready); end
    rst = 1'b1;
    step();
    tests++;
    if (issue_valid !== 1'b0 || fifo_count !== 3'd0 || ir !== 16'h0 || imm !== 16'h0 || has_imm !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_state: got iv=%b cnt=%0d ir=%h imm=%h hi=%b rdy=%b want 0/0/0000/0000/0/1",
               issue_valid, fifo_count, ir, imm, has_imm, in_ready);
    end
  endtask

  task automatic test_single();
    do_reset();
    in_valid = 1'b1; in_data = 16'h1234;
    step();
    in_valid = 1'b0;
    tests++; if (issue_valid !== 1'b0 || fifo_count !== 3'd1) begin fails++; $display("FAIL single_after_push: got iv=%b cnt=%0d want 0/1", issue_valid, fifo_count); end
    step();
    tests++;
    if (issue_valid !== 1'b1 || opcode !== 4'h1 || addrA !== 4'h2 || addrB !== 4'h3 || addrC !== 4'h4 || has_imm !== 1'b0) begin
      fails++;
      $display("FAIL single_decode: got iv=%b op=%h a=%h b=%h c=%h hi=%b want 1/1/2/3/4/0", issue_valid, opcode, addrA, addrB, addrC, has_imm);
    end
    tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL single_count: got %0d want 0", fifo_count); end
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    tests++; if (issue_valid !== 1'b0) begin fails++; $display("FAIL single_drained: got iv=%b want 0", issue_valid); end
  endtask

  task automatic test_imm();
    do_reset();
    in_valid = 1'b1; in_data = 16'hF210;
    step();
    in_data = 16'hBEEF;
    step();
    in_valid = 1'b0;
    tests++; if (issue_valid !== 1'b0 || ir !== 16'hF210) begin fails++; $display("FAIL imm_wait: got iv=%b ir=%h want 0/F210", issue_valid, ir); end
    step();
    tests++;
    if (issue_valid !== 1'b1 || ir !== 16'hF210 || imm !== 16'hBEEF || has_imm !== 1'b1) begin
      fails++;
      $display("FAIL imm_pair: got iv=%b ir=%h imm=%h hi=%b want 1/F210/BEEF/1", issue_valid, ir, imm, has_imm);
    end
    step();
    tests++; if (issue_valid !== 1'b1 || imm !== 16'hBEEF) begin fails++; $display("FAIL imm_hold: got iv=%b imm=%h want 1/BEEF", issue_valid, imm); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w [6];
    w[0] = 16'h1111; w[1] = 16'h2222; w[2] = 16'h3333;
    w[3] = 16'h4444; w[4] = 16'h5555; w[5] = 16'h6666;
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = w[i];
      if (i == 5) begin
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
      end
      step();
    end
    in_valid = 1'b0;
    tests++;
    if (fifo_count !== 3'd4 || in_ready !== 1'b0 || ir !== 16'h1111) begin
      fails++;
      $display("FAIL full_state: got cnt=%0d rdy=%b ir=%h want 4/0/1111", fifo_count, in_ready, ir);
    end
    issue_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (issue_valid !== 1'b1 || ir !== w[i]) begin
        fails++;
        $display("FAIL b2b_word%0d: got iv=%b ir=%h want 1/%h", i, issue_valid, ir, w[i]);
      end
      step();
    end
    issue_ready = 1'b0;
    tests++; if (issue_valid !== 1'b0 || fifo_count !== 3'd0) begin fails++; $display("FAIL b2b_end: got iv=%b cnt=%0d want 0/0", issue_valid, fifo_count); end
  endtask

  task automatic test_flush();
    do_reset();
    in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = 16'(i * 16'h1111);
      step();
    end
    tests++; if (issue_valid !== 1'b1 || fifo_count !== 3'd3) begin fails++; $display("FAIL flush_setup: got iv=%b cnt=%0d want 1/3", issue_valid, fifo_count); end
    flush = 1'b1; in_data = 16'h7777; issue_ready = 1'b1;
    step();
    flush = 1'b0; issue_ready = 1'b0;
    tests++;
    if (fifo_count !== 3'd0 || issue_valid !== 1'b0 || in_ready !== 1'b1 || ir !== 16'h1111) begin
      fails++;
      $display("FAIL flush_state: got cnt=%0d iv=%b rdy=%b ir=%h want 0/0/1/1111", fifo_count, issue_valid, in_ready, ir);
    end
    in_data = 16'h8888;
    step();
    in_valid = 1'b0;
    step();
    tests++; if (issue_valid !== 1'b1 || ir !== 16'h8888 || fifo_count !== 3'd0) begin fails++; $display("FAIL flush_discard: got iv=%b ir=%h cnt=%0d want 1/8888/0", issue_valid, ir, fifo_count); end
  endtask

  task automatic test_async_reset();
    do_reset();
    in_valid = 1'b1; in_data = 16'hF210;
    step();
    in_data = 16'h1234;
    step();
    in_valid = 1'b0;
    tests++; if (ir !== 16'hF210 || fifo_count !== 3'd1) begin fails++; $display("FAIL async_setup: got ir=%h cnt=%0d want F210/1", ir, fifo_count); end
    #2 rst = 1'b0;
    #1;
    tests++;
    if (issue_valid !== 1'b0 || has_imm !== 1'b0 || ir !== 16'h0 || fifo_count !== 3'd0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL async_reset: got iv=%b hi=%b ir=%h cnt=%0d rdy=%b want 0/0/0000/0/1", issue_valid, has_imm, ir, fifo_count, in_ready);
    end
    step();
    rst = 1'b1;
  endtask

  task automatic test_random();
    logic [15:0] q[$];
    int issued = 0;
    do_reset();
    for (int c = 0; c < 1000; c++) begin
      step();
      in_valid = ($urandom_range(0, 1) == 1);
      in_data = 16'($urandom);
      if ($urandom_range(0, 3) == 0) in_data[15:12] = 4'hF;
      issue_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (in_valid && in_ready) q.push_back(in_data);
      if (issue_valid && issue_ready) begin
        tests++;
        issued++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL rand_issue%0d: got ir=%h with nothing pushed", issued, ir);
        end else if (q[0][15:12] == 4'hF) begin
          if (q.size() < 2 || ir !== q[0] || has_imm !== 1'b1 || imm !== q[1]) begin
            fails++;
            $display("FAIL rand_issue%0d: got ir=%h imm=%h hi=%b want ir=%h imm=%h hi=1",
                     issued, ir, imm, has_imm, q[0], (q.size() > 1) ? q[1] : 16'hx);
          end
          void'(q.pop_front());
          if (q.size() > 0) void'(q.pop_front());
        end else begin
          if (ir !== q[0] || has_imm !== 1'b0) begin
            fails++;
            $display("FAIL rand_issue%0d: got ir=%h hi=%b want ir=%h hi=0", issued, ir, has_imm, q[0]);
          end
          void'(q.pop_front());
        end
      end
    end
    in_valid = 1'b0; issue_ready = 1'b0;
    tests++; if (issued < 100) begin fails++; $display("FAIL rand_throughput: got %0d issues want >=100", issued); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_imm();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ir_prefetch_queue.md
Name: ir_prefetch_queue

Overview:
- Parametrised successor to the single-word instruction register.
- Adds a DEPTH-entry prefetch FIFO between instruction memory and the IR, plus a valid/ready fetch side and a valid/ready issue side.
- Supports two-word instructions: when the opcode equals IMM_OPCODE, the following word is captured as an immediate.
- Sits between instruction memory/fetch logic and the control unit/register-file muxes.

Parameters:
- DATA_W, 16, instruction word width.
- FIELD_W, 4, width of the opcode, addrA, addrB and addrC fields. DATA_W must be >= 4*FIELD_W.
- DEPTH, 4, prefetch FIFO entries. Must be a power of 2 and >= 2.
- IMM_OPCODE, 4'hF, opcode value (FIELD_W bits) that marks a two-word instruction.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous flush of the FIFO and IR (branch/jump).
- in_data  in  DATA_W  word from instruction memory.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  FIFO can accept a word.
- issue_valid  out  1  IR (and imm, if needed) holds a complete instruction.
- issue_ready  in  1  control unit consumes the instruction.
- opcode  out  FIELD_W  IR[DATA_W-1 -: FIELD_W].
- addrA  out  FIELD_W  IR[4*FIELD_W-FIELD_W-1 -: FIELD_W], i.e. IR[11:8] at defaults.
- addrB  out  FIELD_W  IR[7:4] at defaults.
- addrC  out  FIELD_W  IR[3:0] at defaults.
- ir  out  DATA_W  raw IR contents.
- imm  out  DATA_W  immediate word; valid only when has_imm=1.
- has_imm  out  1  the current instruction is two-word.
- fifo_count  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (rst=0, async): FIFO pointers and count = 0, ir=0, imm=0, has_imm=0, issue_valid=0, FSM=EMPTY. Therefore in_ready=1 during and after reset. FIFO storage contents are don't-care.
- Push: in_valid && in_ready at an edge writes the FIFO at wr_ptr. in_ready = (fifo_count != DEPTH), registered-state based with no combinational path from issue_ready.
- Pop: internal only, issued by the FSM when FIFO count > 0.
- Same-cycle push and pop: both occur, count unchanged. Pointers wrap modulo DEPTH.
- FSM states:
  - EMPTY: if count>0, pop the head into ir. If the popped opcode==IMM_OPCODE, go to WAIT_IMM; else go to READY.
  - WAIT_IMM: if count>0, pop into imm, set has_imm=1, go to READY; else stay.
  - READY: issue_valid=1. On issue_ready, refill:
    - if count>0, pop the next word into ir (same edge), clear has_imm, and go to WAIT_IMM or READY per its opcode;
    - else go to EMPTY.
- issue_valid is 1 only in READY. ir, imm and the decoded fields are stable while issue_valid=1 && !issue_ready.
- Latency:
  - Word pushed into an empty queue at edge k: ir loaded at edge k+1, issue_valid=1 after k+1.
  - Two-word instruction: imm loaded at k+2 at the earliest; issue_valid=1 after k+2.
- Back-to-back issue: one instruction per cycle sustained when the FIFO is non-empty and all instructions are one-word.
- A word is never dropped or duplicated. A word entering through in_data is never bypassed directly into ir; it always passes through the FIFO.
- Flush (synchronous, at the edge): count=0, pointers=0, FSM=EMPTY, has_imm=0. ir/imm keep their values but issue_valid=0. A push in the same cycle as flush is discarded. Flush has priority over issue_ready.
- Reset mid-operation (e.g. in WAIT_IMM): immediate return to the reset values.
- Full FIFO with in_valid=1: in_ready=0, no write. An issue in the same cycle frees an entry, but in_ready only rises on the next cycle.

Test Plan:
- Reset then push 16'h1234 with issue_ready=0 -> after 1 edge issue_valid=1, opcode=1, addrA=2, addrB=3, addrC=4, has_imm=0; fifo_count returns to 0.
- Push 16'hF210 then 16'hBEEF -> issue_valid stays 0 until the second word lands; then ir=F210, imm=BEEF, has_imm=1.
- Hold issue_ready=0 and push 6 words with DEPTH=4 -> 1 in ir, 4 in FIFO, in_ready=0 and fifo_count=4. Then issue_ready=1 -> words emerge in order, one per cycle, with no loss.
- Assert flush while in READY with 3 words queued and in_valid=1 -> next cycle fifo_count=0, issue_valid=0, in_ready=1, and the pushed word does not appear later.
- Assert rst=0 asynchronously, mid-cycle, while in WAIT_IMM -> issue_valid, has_imm, ir and fifo_count go to 0 immediately, without a clock edge.
- Random in_valid/issue_ready over 1000 cycles with a scoreboard -> issued sequence (including imm pairing) equals the pushed sequence.
